dffram256x16_wrap: RTL and testbench

- Single-port 256-word x 16-bit synchronous RAM built from flip-flops, with two byte write-enables.
- Wraps the DFFRAM macro behind a clean, synthesizable interface for the SPI cache data store.
- One shared address serves both reads and writes.
- Read data is registered, giving one-cycle read latency.

---
 rtl/dffram256x16_wrap.sv | 59 +++++
 tb/tb_dffram256x16_wrap.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dffram256x16_wrap.sv
// 256x16 flip-flop RAM with per-byte write enables and a registered, read-first output.
// Shared address for read and write; one-cycle read latency.
module dffram256x16_wrap (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef USE_POWER_PINS
  inout  wire         VPWR,
  inout  wire         VGND,
`endif
  input  logic        EN0,
  input  logic [1:0]  WE0,
  input  logic [7:0]  A0,
  input  logic [15:0] Di0,
  output logic [15:0] Do0
);

  localparam int unsigned WSIZE = 2;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned DW    = WSIZE * 8;

  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    do_q;
  logic [DW-1:0]    do_d;
  logic [WSIZE-1:0] lane_wr;

  // Per-lane write strobes; reset and a disabled port both suppress writes.
  always_comb begin
    lane_wr = '0;
    if (!rst_i && EN0) begin
      lane_wr = WE0;
    end
  end

  // Flop array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk_i) begin
    for (int unsigned l = 0; l < WSIZE; l++) begin
      if (lane_wr[l]) begin
        mem[A0][l*8 +: 8] <= Di0[l*8 +: 8];
      end
    end
  end

  // Read-first: the array read here sees the word before this edge's write.
  always_comb begin
    do_d = do_q;
    if (rst_i) begin
      do_d = '0;
    end else if (EN0) begin
      do_d = mem[A0];
    end
  end

  always_ff @(posedge clk_i) begin
    do_q <= do_d;
  end

  assign Do0 = do_q;

endmodule

// File: tb/tb_dffram256x16_wrap.sv
// Directed self-checking bench for dffram256x16_wrap.
// Inputs change 1 ns after the rising edge; Do0 is sampled there too.
module tb_dffram256x16_wrap;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        EN0;
  logic [1:0]  WE0;
  logic [7:0]  A0;
  logic [15:0] Di0;
  logic [15:0] Do0;

  int cmp_cnt = 0;
  int err_cnt = 0;

  dffram256x16_wrap dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .EN0   (EN0),
    .WE0   (WE0),
    .A0    (A0),
    .Di0   (Di0),
    .Do0   (Do0)
  );

  always #5 clk_i = ~clk_i;

  // Apply inputs, then let one rising edge consume them.
  task automatic drive(input logic en, input logic [1:0] we, input logic [7:0] a,
                       input logic [15:0] di);
    EN0 = en; WE0 = we; A0 = a; Di0 = di;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    drive(1'b1, 2'b00, 8'd5, 16'h0000);
    drive(1'b1, 2'b00, 8'd5, 16'h0000);
    cmp_cnt++;
    if (Do0 !== 16'h0000) begin
      err_cnt++; $display("FAIL reset_do: got %h expected 0000", Do0);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 256; i++) drive(1'b1, 2'b11, 8'(i), 16'(i));
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'b00, 8'(i), 16'hFFFF);
      cmp_cnt++;
      if (Do0 !== 16'(i)) begin
        err_cnt++; $display("FAIL sweep_rd[%0d]: got %h expected %h", i, Do0, 16'(i));
      end
    end
  endtask

  task automatic test_byte_lanes;
    logic [15:0] exp [5];
    exp = '{16'h0010, 16'hA5C3, 16'hA534, 16'hA534, 16'h5634};
    drive(1'b1, 2'b11, 8'h10, 16'hA5C3);
    cmp_cnt++;
    if (Do0 !== exp[0]) begin err_cnt++; $display("FAIL lane_wr0: got %h expected %h", Do0, exp[0]); end
    drive(1'b1, 2'b01, 8'h10, 16'h1234);
    cmp_cnt++;
    if (Do0 !== exp[1]) begin err_cnt++; $display("FAIL lane_wr1: got %h expected %h", Do0, exp[1]); end
    drive(1'b1, 2'b00, 8'h10, 16'h0000);
    cmp_cnt++;
    if (Do0 !== exp[2]) begin err_cnt++; $display("FAIL lane_rd1: got %h expected %h", Do0, exp[2]); end
    drive(1'b1, 2'b10, 8'h10, 16'h5678);
    cmp_cnt++;
    if (Do0 !== exp[3]) begin err_cnt++; $display("FAIL lane_wr2: got %h expected %h", Do0, exp[3]); end
    drive(1'b1, 2'b00, 8'h10, 16'h0000);
    cmp_cnt++;
    if (Do0 !== exp[4]) begin err_cnt++; $display("FAIL lane_rd2: got %h expected %h", Do0, exp[4]); end
  endtask

  task automatic test_enable;
    drive(1'b1, 2'b11, 8'd3, 16'hBEEF);
    cmp_cnt++;
    if (Do0 !== 16'h0003) begin err_cnt++; $display("FAIL en_wr: got %h expected 0003", Do0); end
    drive(1'b1, 2'b00, 8'd9, 16'h0000);
    cmp_cnt++;
    if (Do0 !== 16'h0009) begin err_cnt++; $display("FAIL en_pre: got %h expected 0009", Do0); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 2'b11, 8'd3, 16'h0000);
      cmp_cnt++;
      if (Do0 !== 16'h0009) begin
        err_cnt++; $display("FAIL en_hold[%0d]: got %h expected 0009", k, Do0);
      end
    end
    drive(1'b1, 2'b00, 8'd3, 16'h0000);
    cmp_cnt++;
    if (Do0 !== 16'hBEEF) begin err_cnt++; $display("FAIL en_rd: got %h expected beef", Do0); end
  endtask

  task automatic test_no_comb_path;
    // Do0 currently holds BEEF from addr 3; mid-cycle input changes must not show through.
    A0 = 8'd7; EN0 = 1'b1; WE0 = 2'b11; Di0 = 16'h4444;
    #3;
    cmp_cnt++;
    if (Do0 !== 16'hBEEF) begin err_cnt++; $display("FAIL comb_path: got %h expected beef", Do0); end
    WE0 = 2'b00;
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 2'b11, 8'd7, 16'h1111);
    cmp_cnt++;
    if (Do0 !== 16'h0007) begin err_cnt++; $display("FAIL b2b_wr1: got %h expected 0007", Do0); end
    drive(1'b1, 2'b11, 8'd7, 16'h2222);
    cmp_cnt++;
    if (Do0 !== 16'h1111) begin err_cnt++; $display("FAIL b2b_wr2: got %h expected 1111", Do0); end
    drive(1'b1, 2'b00, 8'd7, 16'h0000);
    cmp_cnt++;
    if (Do0 !== 16'h2222) begin err_cnt++; $display("FAIL b2b_rd: got %h expected 2222", Do0); end
  endtask

  task automatic test_addr_indep;
    logic [7:0]  addr [3];
    logic [15:0] exp  [3];
    addr = '{8'h00, 8'hFF, 8'h01};
    exp  = '{16'h0F0F, 16'hF0F0, 16'h0001};
    drive(1'b1, 2'b11, 8'h00, 16'h0F0F);
    drive(1'b1, 2'b11, 8'hFF, 16'hF0F0);
    cmp_cnt++;
    if (Do0 !== 16'h00FF) begin err_cnt++; $display("FAIL ai_wr255: got %h expected 00ff", Do0); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b00, addr[k], 16'h0000);
      cmp_cnt++;
      if (Do0 !== exp[k]) begin
        err_cnt++; $display("FAIL ai_rd[%h]: got %h expected %h", addr[k], Do0, exp[k]);
      end
    end
  endtask

  task automatic test_reset_persist;
    // Reset beats a concurrent write request; array contents survive.
    rst_i = 1'b1;
    drive(1'b1, 2'b11, 8'd5, 16'hFFFF);
    drive(1'b1, 2'b11, 8'd5, 16'hFFFF);
    cmp_cnt++;
    if (Do0 !== 16'h0000) begin err_cnt++; $display("FAIL rp_do: got %h expected 0000", Do0); end
    rst_i = 1'b0;
    drive(1'b1, 2'b00, 8'd5, 16'h0000);
    cmp_cnt++;
    if (Do0 !== 16'h0005) begin err_cnt++; $display("FAIL rp_rd5: got %h expected 0005", Do0); end
    drive(1'b1, 2'b00, 8'h10, 16'h0000);
    cmp_cnt++;
    if (Do0 !== 16'h5634) begin err_cnt++; $display("FAIL rp_rd10: got %h expected 5634", Do0); end
  endtask

  initial begin
    rst_i = 1'b1; EN0 = 1'b0; WE0 = 2'b00; A0 = 8'd0; Di0 = 16'h0000;
    #1;
    test_reset();
    test_sweep();
    test_byte_lanes();
    test_enable();
    test_no_comb_path();
    test_back_to_back();
    test_addr_indep();
    test_reset_persist();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
